// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : 5-stage MIPS hazard controller: EX/MEM destination scoreboard,
//            RAW / load-use stall, branch flush and saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int CNT_W      = 16,
    parameter int FORWARDING = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0]       c_st_run   = 1'b0;
    localparam logic [0:0]       c_st_stall = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [REG_W-1:0] c_reg_zero = '0;

    logic [0:0]       r_state;
    logic             r_ex_v;
    logic [REG_W-1:0] r_ex_dst;
    logic             r_ex_load;
    logic             r_mem_v;
    logic [REG_W-1:0] r_mem_dst;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_ex_writing;
    logic w_mem_writing;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_stall;

    // Register 0 is hardwired, so a producer targeting it is never a hazard.
    assign w_ex_writing  = r_ex_v  && (r_ex_dst  != c_reg_zero);
    assign w_mem_writing = r_mem_v && (r_mem_dst != c_reg_zero);

    assign w_hit_ex  = id_valid && w_ex_writing &&
                       ((id_use_rs && (id_rs == r_ex_dst)) ||
                        (id_use_rt && (id_rt == r_ex_dst)));
    assign w_hit_mem = id_valid && w_mem_writing &&
                       ((id_use_rs && (id_rs == r_mem_dst)) ||
                        (id_use_rt && (id_rt == r_mem_dst)));

    generate
        if (FORWARDING != 0) begin : g_fwd
            assign w_stall = w_hit_ex && r_ex_load;
        end else begin : g_nofwd
            assign w_stall = w_hit_ex || w_hit_mem;
        end
    endgenerate

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_run;
            r_ex_v      <= 1'b0;
            r_ex_dst    <= '0;
            r_ex_load   <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_dst   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_mem_v   <= r_ex_v;
            r_mem_dst <= r_ex_dst;
            r_ex_v    <= id_valid && id_wr && !idex_bubble;
            r_ex_dst  <= id_dst;
            r_ex_load <= id_load;

            // A taken branch squashes the stalled instruction, so it wins.
            if (ex_branch_taken) begin
                r_state <= c_st_run;
                if (r_flush_cnt != c_cnt_max) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end else if (w_stall) begin
                r_state <= c_st_stall;
                if (r_stall_cnt != c_cnt_max) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_state <= c_st_run;
            end
        end
    end

    assign stall_active = (r_state == c_st_stall);
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed scoreboard bench for hazard_ctrl (no-forwarding and
//            forwarding variants); expected responses are queued per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam logic [3:0] c_o_run   = 4'b1100;   // {pc_en, ifid_en, ifid_flush, idex_bubble}
    localparam logic [3:0] c_o_stall = 4'b0001;
    localparam logic [3:0] c_o_flush = 4'b1111;
    localparam logic [3:0] c_o_rst   = 4'b0011;

    typedef struct {
        logic        sel;
        logic        chk;
        logic [3:0]  o;
        logic        sa;
        logic [15:0] sc;
        logic [15:0] fc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic       v0 = 0, urs0 = 0, urt0 = 0, wr0 = 0, ld0 = 0, br0 = 0;
    logic [4:0] rs0 = 0, rt0 = 0, dst0 = 0;
    logic       v1 = 0, urs1 = 0, urt1 = 0, wr1 = 0, ld1 = 0, br1 = 0;
    logic [4:0] rs1 = 0, rt1 = 0, dst1 = 0;

    logic       pc0, ife0, fl0, bub0, sa0;
    logic [3:0] sc0, fc0;
    logic       pc1, ife1, fl1, bub1, sa1;
    logic [15:0] sc1, fc1;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .CNT_W(4), .FORWARDING(0)) u_nofwd (
        .clock(clk), .reset(reset),
        .id_valid(v0), .id_rs(rs0), .id_rt(rt0), .id_use_rs(urs0), .id_use_rt(urt0),
        .id_dst(dst0), .id_wr(wr0), .id_load(ld0), .ex_branch_taken(br0),
        .pc_en(pc0), .ifid_en(ife0), .ifid_flush(fl0), .idex_bubble(bub0),
        .stall_active(sa0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.REG_W(5), .CNT_W(16), .FORWARDING(1)) u_fwd (
        .clock(clk), .reset(reset),
        .id_valid(v1), .id_rs(rs1), .id_rt(rt1), .id_use_rs(urs1), .id_use_rt(urt1),
        .id_dst(dst1), .id_wr(wr1), .id_load(ld1), .ex_branch_taken(br1),
        .pc_en(pc1), .ifid_en(ife1), .ifid_flush(fl1), .idex_bubble(bub1),
        .stall_active(sa1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    // One call = one clock cycle of ID-stage stimulus plus its expected response.
    task automatic step(input logic s, input logic rst_v, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic wr, input logic ld, input logic br,
                        input logic [3:0] eo, input logic chk, input logic esa,
                        input int esc, input int efc, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v;
        v0 = 0; urs0 = 0; urt0 = 0; wr0 = 0; ld0 = 0; br0 = 0; rs0 = 0; rt0 = 0; dst0 = 0;
        v1 = 0; urs1 = 0; urt1 = 0; wr1 = 0; ld1 = 0; br1 = 0; rs1 = 0; rt1 = 0; dst1 = 0;
        if (s == 1'b0) begin
            v0 = v; rs0 = rs; rt0 = rt; urs0 = urs; urt0 = urt; dst0 = dst; wr0 = wr; ld0 = ld; br0 = br;
        end else begin
            v1 = v; rs1 = rs; rt1 = rt; urs1 = urs; urt1 = urt; dst1 = dst; wr1 = wr; ld1 = ld; br1 = br;
        end
        e.sel = s; e.chk = chk; e.o = eo; e.sa = esa;
        e.sc = 16'(esc); e.fc = 16'(efc); e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic nop(input logic s, input logic [3:0] eo, input logic esa,
                       input int esc, input int efc, input string tag);
        step(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, 1, esa, esc, efc, tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [3:0] ao;
            logic       asa;
            logic [15:0] asc, afc;
            e = exp_q.pop_front();
            if (e.sel == 1'b0) begin
                ao = {pc0, ife0, fl0, bub0}; asa = sa0; asc = {12'b0, sc0}; afc = {12'b0, fc0};
            end else begin
                ao = {pc1, ife1, fl1, bub1}; asa = sa1; asc = sc1; afc = fc1;
            end
            n_cmp++;
            if (ao !== e.o || (e.chk && (asa !== e.sa || asc !== e.sc || afc !== e.fc))) begin
                n_fail++;
                $display("FAIL %s: got pc/ife/fl/bub=%b sa=%b sc=%0d fc=%0d, want %b sa=%b sc=%0d fc=%0d",
                         e.tag, ao, asa, asc, afc, e.o, e.sa, e.sc, e.fc);
            end
        end
    end

    initial begin
        int s;
        // Reset: first cycle registers are still unknown, so only outputs are checked.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_o_rst, 0, 0, 0, 0, "reset_c0");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_o_rst, 1, 0, 0, 0, "reset_c1");
        nop(0, c_o_run, 0, 0, 0, "post_reset");

        // add $3 then sub reading $3: two stall cycles without forwarding.
        step(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, 0, c_o_run,   1, 0, 0, 0, "raw_producer");
        step(0, 0, 1, 3, 4, 1, 1, 6, 1, 0, 0, c_o_stall, 1, 0, 0, 0, "raw_stall_ex");
        step(0, 0, 1, 3, 4, 1, 1, 6, 1, 0, 0, c_o_stall, 1, 1, 1, 0, "raw_stall_mem");
        step(0, 0, 1, 3, 4, 1, 1, 6, 1, 0, 0, c_o_run,   1, 1, 2, 0, "raw_release");
        nop(0, c_o_run, 0, 2, 0, "raw_after");

        // Producer writing $0, reader of $0, then an invalid ID with matching fields.
        step(0, 0, 1, 1, 2, 1, 1, 0, 1, 0, 0, c_o_run, 1, 0, 2, 0, "zero_producer");
        step(0, 0, 1, 0, 0, 1, 1, 7, 1, 0, 0, c_o_run, 1, 0, 2, 0, "zero_reader");
        step(0, 0, 0, 7, 7, 1, 1, 8, 1, 0, 0, c_o_run, 1, 0, 2, 0, "invalid_id_match");
        nop(0, c_o_run, 0, 2, 0, "drain");

        // Branch taken on the first hazard cycle: flush wins over stall.
        step(0, 0, 1, 1, 2, 1, 1, 9, 1, 0, 0, c_o_run,   1, 0, 2, 0, "br_producer");
        step(0, 0, 1, 9, 0, 1, 0, 4, 1, 0, 1, c_o_flush, 1, 0, 2, 0, "br_vs_stall");
        nop(0, c_o_run, 0, 2, 1, "br_after");

        // Branch taken while already in STALL.
        step(0, 0, 1, 1, 2, 1, 1, 10, 1, 0, 0, c_o_run,   1, 0, 2, 1, "br2_producer");
        step(0, 0, 1, 10, 0, 1, 0, 4, 1, 0, 0, c_o_stall, 1, 0, 2, 1, "br2_stall");
        step(0, 0, 1, 10, 0, 1, 0, 4, 1, 0, 1, c_o_flush, 1, 1, 3, 1, "br2_in_stall");
        nop(0, c_o_run, 0, 3, 2, "br2_after");

        // Repeated two-cycle stalls drive the 4-bit stall counter into saturation.
        s = 3;
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 1, 1, 2, 1, 1, 11, 1, 0, 0, c_o_run,   1, 0, s, 2, "sat_producer");
            step(0, 0, 1, 11, 0, 1, 0, 0, 0, 0, 0, c_o_stall, 1, 0, s, 2, "sat_stall1");
            step(0, 0, 1, 11, 0, 1, 0, 0, 0, 0, 0, c_o_stall, 1, 1, (s + 1 > 15) ? 15 : s + 1, 2, "sat_stall2");
            s = (s + 2 > 15) ? 15 : s + 2;
            step(0, 0, 1, 11, 0, 1, 0, 0, 0, 0, 0, c_o_run,   1, 1, s, 2, "sat_release");
        end

        // Reset while a hazard is stalling ID: the producer must be dropped.
        step(0, 0, 1, 1, 2, 1, 1, 12, 1, 0, 0, c_o_run, 1, 0, 15, 2, "rst_producer");
        step(0, 1, 1, 12, 0, 1, 0, 0, 0, 0, 0, c_o_rst, 1, 0, 15, 2, "rst_mid_stall");
        step(0, 0, 1, 12, 0, 1, 0, 0, 0, 0, 0, c_o_run, 1, 0, 0, 0, "rst_sb_empty");

        // Forwarding variant: load-use stalls once, ALU producer never stalls.
        step(1, 0, 1, 1, 2, 1, 1, 5, 1, 1, 0, c_o_run,   1, 0, 0, 0, "fw_load");
        step(1, 0, 1, 5, 0, 1, 0, 6, 1, 0, 0, c_o_stall, 1, 0, 0, 0, "fw_load_use");
        step(1, 0, 1, 5, 0, 1, 0, 6, 1, 0, 0, c_o_run,   1, 1, 1, 0, "fw_load_release");
        step(1, 0, 1, 1, 2, 1, 1, 5, 1, 0, 0, c_o_run,   1, 0, 1, 0, "fw_add");
        step(1, 0, 1, 5, 0, 1, 0, 7, 1, 0, 0, c_o_run,   1, 0, 1, 0, "fw_add_use_ex");
        step(1, 0, 1, 0, 5, 0, 1, 8, 1, 0, 0, c_o_run,   1, 0, 1, 0, "fw_add_use_mem");
        nop(1, c_o_run, 0, 1, 0, "fw_after");

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS datapath. It keeps a two-entry scoreboard of destination registers in flight in EX and MEM, and compares it against the source registers of the instruction in ID. From that comparison it drives PC-enable, IF/ID-enable, IF/ID-flush and ID/EX-bubble. It also applies branch-taken flushes and keeps saturating stall and flush counters for the UI debug display. It sits between the controller/register-file decode logic and the IF/ID, ID/EX pipeline registers and the program counter.

## Interface
Parameters:
- `REG_W`, 5: register-address width.
- `CNT_W`, 16: width of the debug counters.
- `FORWARDING`, 0: 0 = no forwarding paths, so every RAW against EX/MEM stalls. 1 = EX/MEM forwarding is present, so only load-use stalls.

Ports:
- `clock` in 1: single system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction (0 = bubble).
- `id_rs` in REG_W: ID source register 1.
- `id_rt` in REG_W: ID source register 2.
- `id_use_rs` in 1: ID reads rs.
- `id_use_rt` in 1: ID reads rt.
- `id_dst` in REG_W: ID destination register.
- `id_wr` in 1: ID writes the register file.
- `id_load` in 1: ID is a load (memory read to register).
- `ex_branch_taken` in 1: branch resolved taken in EX this cycle.
- `pc_en` out 1: PC may advance.
- `ifid_en` out 1: IF/ID may load.
- `ifid_flush` out 1: IF/ID loads a bubble.
- `idex_bubble` out 1: ID/EX loads a bubble (control bits zeroed).
- `stall_active` out 1: registered; 1 while in STALL.
- `stall_cnt` out CNT_W: cycles stalled, saturating.
- `flush_cnt` out CNT_W: flush events, saturating.

## Operation
- Scoreboard entries are EX{v,dst,load} and MEM{v,dst}. An entry counts as writing only if v=1 and dst≠0; register 0 never causes a hazard.
- The register file is write-before-read, so a WB-stage destination never causes a hazard.
- hit_ex = id_valid & ((id_use_rs & rs==EX.dst) | (id_use_rt & rt==EX.dst)) & EX writing. hit_mem is the same comparison against MEM.
- Stall condition:
  - FORWARDING=0: stall = hit_ex | hit_mem.
  - FORWARDING=1: stall = hit_ex & EX.load.
- Output priority, highest first:
  1. reset
  2. ex_branch_taken: flush, whatever the stall state.
  3. stall
  4. run
- Output values per case:
  - Flush: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1; flush_cnt += 1.
  - Stall: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1; stall_cnt += 1.
  - Run: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Scoreboard advances on every clock edge:
  - MEM ← EX.
  - EX ← {id_valid & id_wr & ~idex_bubble, id_dst, id_load}.
  - When a bubble is inserted, EX.v becomes 0.
- FSM states are RUN and STALL.
  - RUN→STALL when stall & ~ex_branch_taken.
  - STALL→RUN when the stall condition clears or a flush occurs.
  - stall_active = (state==STALL).
- Counters saturate at all-ones and do not wrap.

## Timing
- pc_en, ifid_en, ifid_flush and idex_bubble are combinational from scoreboard state and the current ID/EX inputs, so they take effect in the same cycle. All state updates on the rising edge of `clock`.
- Reset values, applied on the edge with reset=1:
  - Scoreboard v=0, state=RUN, stall_active=0, both counters 0.
  - While reset=1, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
  - Counters do not count during reset.
- First cycle after reset: scoreboard empty, so outputs are run values.
- Reset asserted mid-stall: state is discarded and the in-flight bubble is cleared on that same edge.
- RAW hazard stall length, FORWARDING=0:
  - Producer one ahead (in EX): 2 stall cycles.
  - Producer two ahead (in MEM): 1 stall cycle.
- FORWARDING=1, load-use: exactly 1 stall cycle.
- ex_branch_taken in the same cycle as a stall: flush wins. The stalled ID instruction is squashed, stall_cnt is not incremented, and flush_cnt is incremented.
- id_valid=0 never stalls, even if the register fields match.

## Test plan
- Reset: hold reset for 2 cycles, then release → the reset cycles show pc_en=0, ifid_flush=1, idex_bubble=1. The first cycle after release shows pc_en=1, idex_bubble=0, stall_cnt=0, flush_cnt=0.
- FORWARDING=0: issue `add $3` then `sub` reading $3 back-to-back → pc_en=0 for exactly 2 cycles, stall_active=1 during the 2nd, stall_cnt=2, then run.
- FORWARDING=1: issue a load to $5 followed by a use of $5 → one stall cycle (stall_cnt=1). Repeat with an `add` to $5 followed by a use of $5 → no stall.
- Destination $0: a producer writing $0 followed by a reader of $0 → no stall, stall_cnt unchanged.
- Simultaneous branch and stall: a hazard is present and ex_branch_taken=1 in the same cycle → ifid_flush=1, idex_bubble=1, pc_en=1, flush_cnt +1, stall_cnt unchanged, next state RUN.
- Saturation and mid-stall reset:
  - Preload stall_cnt to 0xFFFF via a forced long stall → it stays at 0xFFFF.
  - Assert reset mid-stall → next cycle stall_cnt=0, scoreboard empty.
